// File: rtl/instruction_packer.sv
// Packs field tuples into 16-bit BitEpicness words and streams them
// into instruction memory at consecutive addresses from a base.
module instruction_packer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [ADDR_WIDTH-1:0] Length,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [1:0]            Format,
  input  logic [4:0]            OpCode,
  input  logic [2:0]            FuncCode,
  input  logic [3:0]            Reg1,
  input  logic [3:0]            Reg2,
  input  logic [3:0]            Reg3,
  input  logic [6:0]            Imm,
  input  logic [31:0]           JTarget,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [15:0]           MemData,
  output logic                  Busy,
  output logic                  Done,
  output logic [7:0]            ErrorCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] remain_q, remain_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic [7:0]            err_q, err_d;

  logic        ok;
  logic [15:0] word;

  always_comb begin
    ok   = 1'b0;
    word = '0;
    unique case (Format)
      2'd0: begin
        ok   = ~OpCode[4];
        word = {OpCode, Reg1, Reg2, FuncCode};
      end
      2'd1: begin
        ok   = ~OpCode[4];
        word = {OpCode, Reg1, Imm};
      end
      2'd2: begin
        ok   = (JTarget[31:11] == '0);
        word = {OpCode, JTarget[10:0]};
      end
      default: begin
        // bit 11 is both OpCode[0] and Reg1[3]; they must agree
        ok   = OpCode[4] & (Reg1[3] == OpCode[0]);
        word = {OpCode[4:1], Reg1, Reg2, Reg3};
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          err_d = '0;
          if (Length != '0) begin
            ptr_d    = BaseAddr;
            remain_d = Length;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (InValid) begin
          if (ok) begin
            wr_d     = 1'b1;
            addr_d   = ptr_q;
            data_d   = word;
            ptr_d    = ptr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == ADDR_WIDTH'(1)) state_d = FLUSH;
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // outputs read as idle while Reset is held, so a pending write never shows
  assign InReady    = ~Reset & (state_q == RUN);
  assign Busy       = ~Reset & (state_q != IDLE);
  assign MemWrite   = ~Reset & wr_q;
  assign Done       = ~Reset & done_q;
  assign MemAddr    = Reset ? '0 : addr_q;
  assign MemData    = Reset ? '0 : data_q;
  assign ErrorCount = Reset ? '0 : err_q;

endmodule
